// File: rtl/regfile_mp_sb_if.sv
// Bus between decode / the two writeback stages and the register file with scoreboard.
// Read/issue side sits in decode; write side is fed by the ALU (port 0) and load/mul (port 1) writebacks.
interface regfile_mp_sb_if #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NUM_RD = 2
);
    localparam int AW = $clog2(NREGS);

    // wr_en/iss_en are single-cycle qualifiers with no backpressure: the register file
    // always accepts them at the next posedge. rd_ready is a status flag, not a handshake.
    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_ready;
    logic [1:0]             wr_en;
    logic [2*AW-1:0]        wr_addr;
    logic [2*XLEN-1:0]      wr_data;
    logic                   iss_en;
    logic [AW-1:0]          iss_addr;
    logic [NREGS-1:0]       pend_vec;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_ready, pend_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_ready, pend_vec
    );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port flop-based register file with two write ports, write-to-read bypass
// and a per-register pending scoreboard for RAW stall detection in decode.
module regfile_mp_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic           clk,
    input  logic           rstn,
    regfile_mp_sb_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam bit ZR = (ZERO_REG != 0);

    logic [XLEN-1:0]        regs_q [NREGS];
    logic [XLEN-1:0]        regs_d [NREGS];
    logic [NREGS-1:0]       pend_q, pend_d;
    logic [NREGS-1:0]       clr, set;
    logic [NUM_RD*XLEN-1:0] rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]      rd_ready_q, rd_ready_d;
    logic [NREGS-1:0]       pend_vec_q;
    logic [AW-1:0]          wa [2];
    logic [XLEN-1:0]        wd [2];
    logic [AW-1:0]          ra;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            wa[p] = bus.wr_addr[p*AW +: AW];
            wd[p] = bus.wr_data[p*XLEN +: XLEN];
        end
    end

    // Port 1 is applied after port 0 so it wins a same-address collision.
    always_comb begin
        regs_d = regs_q;
        clr    = '0;
        set    = '0;
        for (int p = 0; p < 2; p++) begin
            if (bus.wr_en[p] && !(ZR && wa[p] == '0)) begin
                regs_d[wa[p]] = wd[p];
                clr[wa[p]]    = 1'b1;
            end
        end
        if (bus.iss_en && !(ZR && bus.iss_addr == '0)) begin
            set[bus.iss_addr] = 1'b1;
        end
        pend_d = (pend_q & ~clr) | set;
    end

    always_comb begin
        rd_data_d  = '0;
        rd_ready_d = '0;
        ra         = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra = bus.rd_addr[i*AW +: AW];
            if (ZR && ra == '0) begin
                rd_ready_d[i] = 1'b1;
            end else begin
                if (bus.wr_en[1] && wa[1] == ra) begin
                    rd_data_d[i*XLEN +: XLEN] = wd[1];
                end else if (bus.wr_en[0] && wa[0] == ra) begin
                    rd_data_d[i*XLEN +: XLEN] = wd[0];
                end else begin
                    rd_data_d[i*XLEN +: XLEN] = regs_q[ra];
                end
                rd_ready_d[i] = ~pend_d[ra];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            regs_q     <= '{default: '0};
            pend_q     <= '0;
            rd_data_q  <= '0;
            rd_ready_q <= '1;
            pend_vec_q <= '0;
        end else begin
            regs_q     <= regs_d;
            pend_q     <= pend_d;
            rd_data_q  <= rd_data_d;
            rd_ready_q <= rd_ready_d;
            pend_vec_q <= pend_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_ready = rd_ready_q;
    assign bus.pend_vec = pend_vec_q;
endmodule
